// File: rtl/signal_config_scheduler_if.sv
// Bundle of config-request, self-test and signal-line wires shared by the
// scheduler (slave side) and whoever drives it (master side).
interface signal_config_scheduler_if;
  logic       CFG_WR;
  logic [7:0] CFG_DATA;
  logic       CFG_BUSY;
  logic       SELFTEST_START;
  logic       SELFTEST_DONE;
  logic       SELFTEST_PASS;
  logic       SIGNAL_LINE_1;
  logic       SIGNAL_LINE_2;
  logic [7:0] MCONFIG;
  logic       BLANK;

  modport slave (
    input  CFG_WR,
    input  CFG_DATA,
    input  SELFTEST_START,
    input  SIGNAL_LINE_1,
    input  SIGNAL_LINE_2,
    output CFG_BUSY,
    output SELFTEST_DONE,
    output SELFTEST_PASS,
    output MCONFIG,
    output BLANK
  );

  modport master (
    output CFG_WR,
    output CFG_DATA,
    output SELFTEST_START,
    output SIGNAL_LINE_1,
    output SIGNAL_LINE_2,
    input  CFG_BUSY,
    input  SELFTEST_DONE,
    input  SELFTEST_PASS,
    input  MCONFIG,
    input  BLANK
  );
endinterface

// File: rtl/signal_config_scheduler.sv
// Applies signal-input config changes only while both lines are quiet, then blanks the lines.
// Optional self-test sequencer is compiled in when SIGNAL_CONFIG_SELFTEST_EN is defined.
module signal_config_scheduler #(
  parameter int unsigned QUIET_CYCLES = 32'd4,
  parameter int unsigned BLANK_CYCLES = 32'd16,
  parameter int unsigned ST_TIMEOUT   = 32'd4096
) (
  input logic                      CLK,
  input logic                      RESET,
  signal_config_scheduler_if.slave bus
);

  localparam int unsigned QW = $clog2(QUIET_CYCLES + 32'd1);
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 32'd1);
  localparam logic [QW-1:0] QUIET_MAX  = QW'(QUIET_CYCLES);
  localparam logic [BW-1:0] BLANK_MAX  = BW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_QUIET = 3'd1,
    APPLY      = 3'd2,
    HOLD_BLANK = 3'd3
`ifdef SIGNAL_CONFIG_SELFTEST_EN
    ,
    ST_CH1     = 3'd4,
    ST_CH2     = 3'd5,
    ST_RESTORE = 3'd6
`endif
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    pending_r, pending_s;
  logic [7:0]    mconfig_r, mconfig_s;
  logic          busy_r, busy_s;
  logic          blank_r, blank_s;
  logic [QW-1:0] quiet_cnt_r, quiet_cnt_s;
  logic [BW-1:0] blank_cnt_r, blank_cnt_s;
  logic          lines_idle_s;

`ifdef SIGNAL_CONFIG_SELFTEST_EN
  localparam int unsigned TW = $clog2(ST_TIMEOUT + 32'd1);
  localparam logic [TW-1:0] TO_MAX  = TW'(ST_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(ST_TIMEOUT - 32'd1);
  // Pulser enabled on one channel at a time; bit0/1 keep both inputs powered.
  localparam logic [7:0] ST_CFG_CH1 = 8'h43;
  localparam logic [7:0] ST_CFG_CH2 = 8'h83;

  logic [7:0]    saved_r, saved_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic          pass1_r, pass1_s;
  logic          pass2_r, pass2_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic          line1_q_r, line2_q_r;
  logic          rise1_s, rise2_s;

  assign rise1_s = bus.SIGNAL_LINE_1 & ~line1_q_r;
  assign rise2_s = bus.SIGNAL_LINE_2 & ~line2_q_r;
`else
  logic unused_selftest_start_s;
  assign unused_selftest_start_s = bus.SELFTEST_START;
`endif

  assign lines_idle_s = ~(bus.SIGNAL_LINE_1 | bus.SIGNAL_LINE_2);

  // Next-state and next-output decode for the scheduler FSM
  always_comb begin
    state_s     = state_r;
    pending_s   = pending_r;
    mconfig_s   = mconfig_r;
    busy_s      = busy_r;
    blank_s     = blank_r;
    quiet_cnt_s = quiet_cnt_r;
    blank_cnt_s = blank_cnt_r;
`ifdef SIGNAL_CONFIG_SELFTEST_EN
    saved_s  = saved_r;
    done_s   = 1'b0;
    pass_s   = pass_r;
    pass1_s  = pass1_r;
    pass2_s  = pass2_r;
    to_cnt_s = to_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.CFG_WR) begin
          pending_s   = bus.CFG_DATA;
          busy_s      = 1'b1;
          quiet_cnt_s = {QW{1'b0}};
          state_s     = WAIT_QUIET;
        end
`ifdef SIGNAL_CONFIG_SELFTEST_EN
        else if (bus.SELFTEST_START) begin
          saved_s   = mconfig_r;
          pass_s    = 1'b0;
          pass1_s   = 1'b0;
          pass2_s   = 1'b0;
          to_cnt_s  = {TW{1'b0}};
          busy_s    = 1'b1;
          blank_s   = 1'b1;
          mconfig_s = ST_CFG_CH1;
          state_s   = ST_CH1;
        end
`endif
        else begin
          busy_s = 1'b0;
        end
      end
      WAIT_QUIET: begin
        // Any activity restarts the quiet window; the change waits for a full idle run.
        if (!lines_idle_s) begin
          quiet_cnt_s = {QW{1'b0}};
        end else if (quiet_cnt_r == QUIET_MAX) begin
          quiet_cnt_s = {QW{1'b0}};
          state_s     = APPLY;
        end else begin
          quiet_cnt_s = quiet_cnt_r + QW'(1'b1);
        end
      end
      APPLY: begin
        mconfig_s   = pending_r;
        blank_s     = 1'b1;
        blank_cnt_s = {BW{1'b0}};
        state_s     = HOLD_BLANK;
      end
      HOLD_BLANK: begin
        if (blank_cnt_r == BLANK_LAST) begin
          blank_s     = 1'b0;
          busy_s      = 1'b0;
          blank_cnt_s = {BW{1'b0}};
          state_s     = IDLE;
        end else if (blank_cnt_r == BLANK_MAX) begin
          blank_cnt_s = blank_cnt_r;
        end else begin
          blank_cnt_s = blank_cnt_r + BW'(1'b1);
        end
      end
`ifdef SIGNAL_CONFIG_SELFTEST_EN
      ST_CH1: begin
        if (rise1_s) begin
          pass1_s   = 1'b1;
          mconfig_s = ST_CFG_CH2;
          to_cnt_s  = {TW{1'b0}};
          state_s   = ST_CH2;
        end else if (to_cnt_r == TO_LAST) begin
          pass1_s   = 1'b0;
          mconfig_s = ST_CFG_CH2;
          to_cnt_s  = {TW{1'b0}};
          state_s   = ST_CH2;
        end else if (to_cnt_r == TO_MAX) begin
          to_cnt_s = to_cnt_r;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1'b1);
        end
      end
      ST_CH2: begin
        if (rise2_s) begin
          pass2_s  = 1'b1;
          to_cnt_s = {TW{1'b0}};
          state_s  = ST_RESTORE;
        end else if (to_cnt_r == TO_LAST) begin
          pass2_s  = 1'b0;
          to_cnt_s = {TW{1'b0}};
          state_s  = ST_RESTORE;
        end else if (to_cnt_r == TO_MAX) begin
          to_cnt_s = to_cnt_r;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1'b1);
        end
      end
      ST_RESTORE: begin
        // The restored config gets its own full blanking window.
        mconfig_s   = saved_r;
        done_s      = 1'b1;
        pass_s      = pass1_r & pass2_r;
        blank_cnt_s = {BW{1'b0}};
        state_s     = HOLD_BLANK;
      end
`endif
      default: begin
        busy_s  = 1'b0;
        blank_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      pending_r   <= 8'h00;
      mconfig_r   <= 8'h00;
      busy_r      <= 1'b0;
      blank_r     <= 1'b0;
      quiet_cnt_r <= {QW{1'b0}};
      blank_cnt_r <= {BW{1'b0}};
`ifdef SIGNAL_CONFIG_SELFTEST_EN
      saved_r   <= 8'h00;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      pass1_r   <= 1'b0;
      pass2_r   <= 1'b0;
      to_cnt_r  <= {TW{1'b0}};
      line1_q_r <= 1'b0;
      line2_q_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      mconfig_r   <= mconfig_s;
      busy_r      <= busy_s;
      blank_r     <= blank_s;
      quiet_cnt_r <= quiet_cnt_s;
      blank_cnt_r <= blank_cnt_s;
`ifdef SIGNAL_CONFIG_SELFTEST_EN
      saved_r   <= saved_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      pass1_r   <= pass1_s;
      pass2_r   <= pass2_s;
      to_cnt_r  <= to_cnt_s;
      line1_q_r <= bus.SIGNAL_LINE_1;
      line2_q_r <= bus.SIGNAL_LINE_2;
`endif
    end
  end

  assign bus.MCONFIG  = mconfig_r;
  assign bus.BLANK    = blank_r;
  assign bus.CFG_BUSY = busy_r;
`ifdef SIGNAL_CONFIG_SELFTEST_EN
  assign bus.SELFTEST_DONE = done_r;
  assign bus.SELFTEST_PASS = pass_r;
`else
  assign bus.SELFTEST_DONE = 1'b0;
  assign bus.SELFTEST_PASS = 1'b0;
`endif

endmodule

// File: tb/tb_signal_config_scheduler.sv
// Directed + randomized bench for signal_config_scheduler; expected timing is
// derived from line-activity history, not from the design's state machine.
module tb_signal_config_scheduler;
  localparam int Q = 4;
  localparam int B = 16;
  localparam int T = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;
  logic [7:0] model_cfg;
  logic       model_pass;
  logic       l1_pat[$];
  logic       l2_pat[$];

  signal_config_scheduler_if bus();

  signal_config_scheduler #(
    .QUIET_CYCLES(Q),
    .BLANK_CYCLES(B),
    .ST_TIMEOUT(T)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] cfg, input logic blank,
                             input logic busy, input logic done, input logic pass);
    chk({tag, "_mconfig"}, {24'd0, bus.MCONFIG}, {24'd0, cfg});
    chk({tag, "_blank"}, {31'd0, bus.BLANK}, {31'd0, blank});
    chk({tag, "_busy"}, {31'd0, bus.CFG_BUSY}, {31'd0, busy});
    chk({tag, "_done"}, {31'd0, bus.SELFTEST_DONE}, {31'd0, done});
    chk({tag, "_pass"}, {31'd0, bus.SELFTEST_PASS}, {31'd0, pass});
  endtask

  // Index j (sample at request edge + 1 + j) completing Q+1 consecutive idle samples.
  function automatic int quiet_edge();
    int   run;
    logic hot;
    run = 0;
    for (int j = 0; j < 100000; j++) begin
      hot = (j < l1_pat.size() && l1_pat[j]) || (j < l2_pat.size() && l2_pat[j]);
      if (hot) run = 0;
      else run++;
      if (run == Q + 1) return j;
    end
    return -1;
  endfunction

  task automatic run_cfg(input string tag, input logic [7:0] data, input logic start_too,
                         input logic extra_wr, input logic [7:0] extra_data);
    int dm;
    int wr_at;
    logic [7:0] old_cfg;
    old_cfg = model_cfg;
    dm = quiet_edge() + 2;
    wr_at = extra_wr ? int'($urandom_range(1, dm + B - 1)) : -1;
    bus.CFG_DATA = data;
    bus.CFG_WR = 1'b1;
    bus.SELFTEST_START = start_too;
    tick();
    bus.CFG_WR = 1'b0;
    bus.SELFTEST_START = 1'b0;
    chk_outputs({tag, "_req"}, old_cfg, 1'b0, 1'b1, 1'b0, model_pass);
    for (int d = 1; d <= dm + B + 2; d++) begin
      bus.SIGNAL_LINE_1 = (d - 1 < l1_pat.size()) ? l1_pat[d-1] : 1'b0;
      bus.SIGNAL_LINE_2 = (d - 1 < l2_pat.size()) ? l2_pat[d-1] : 1'b0;
      bus.CFG_WR = (d == wr_at);
      bus.SELFTEST_START = (d == wr_at);
      bus.CFG_DATA = (d == wr_at) ? extra_data : data;
      tick();
      chk_outputs(tag, (d >= dm) ? data : old_cfg, (d >= dm) && (d < dm + B),
                  (d < dm + B), 1'b0, model_pass);
    end
    bus.CFG_WR = 1'b0;
    bus.SELFTEST_START = 1'b0;
    bus.SIGNAL_LINE_1 = 1'b0;
    bus.SIGNAL_LINE_2 = 1'b0;
    model_cfg = data;
    l1_pat.delete();
    l2_pat.delete();
  endtask

`ifdef SIGNAL_CONFIG_SELFTEST_EN
  // d1/d2: cycle of the line pulse counted from channel entry, 0 = never pulsed.
  task automatic run_st(input string tag, input int d1, input int d2);
    int e1;
    int e2;
    logic p;
    logic [7:0] old_cfg;
    logic [7:0] exp_cfg;
    old_cfg = model_cfg;
    e1 = (d1 > 0) ? d1 : T;
    e2 = e1 + ((d2 > 0) ? d2 : T);
    p = (d1 > 0) && (d2 > 0);
    bus.SELFTEST_START = 1'b1;
    tick();
    bus.SELFTEST_START = 1'b0;
    chk_outputs({tag, "_start"}, 8'h43, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= e2 + B + 3; t++) begin
      bus.SIGNAL_LINE_1 = (d1 > 0) && (t == d1 || t == d1 + 1);
      bus.SIGNAL_LINE_2 = (d2 > 0) && (t == e1 + d2 || t == e1 + d2 + 1);
      tick();
      exp_cfg = (t < e1) ? 8'h43 : ((t <= e2) ? 8'h83 : old_cfg);
      chk_outputs(tag, exp_cfg, (t < e2 + 1 + B), (t < e2 + 1 + B), (t == e2 + 1),
                  (t >= e2 + 1) ? p : 1'b0);
    end
    bus.SIGNAL_LINE_1 = 1'b0;
    bus.SIGNAL_LINE_2 = 1'b0;
    model_pass = p;
  endtask
`endif

  initial begin
    logic [7:0] rd;
    bus.CFG_WR = 1'b0;
    bus.CFG_DATA = 8'h00;
    bus.SELFTEST_START = 1'b0;
    bus.SIGNAL_LINE_1 = 1'b0;
    bus.SIGNAL_LINE_2 = 1'b0;
    model_cfg = 8'h00;
    model_pass = 1'b0;

    repeat (3) tick();
    chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_outputs("post_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    run_cfg("cfg03", 8'h03, 1'b0, 1'b0, 8'h00);

    for (int j = 0; j < 50; j++) l1_pat.push_back((j % 3) == 0);
    run_cfg("pulsing", 8'h0F, 1'b0, 1'b0, 8'h00);

    run_cfg("second_wr", 8'h3C, 1'b0, 1'b1, 8'hFF);
    run_cfg("wr_and_start", 8'h21, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 8; i++) begin
      int len;
      len = int'($urandom_range(0, 30));
      for (int j = 0; j < len; j++) begin
        l1_pat.push_back($urandom_range(0, 2) == 0);
        l2_pat.push_back($urandom_range(0, 3) == 0);
      end
      rd = 8'($urandom);
      run_cfg("random", rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd ^ 8'hFF);
    end

`ifdef SIGNAL_CONFIG_SELFTEST_EN
    run_cfg("cfg03_again", 8'h03, 1'b0, 1'b0, 8'h00);
    run_st("st_pass", int'($urandom_range(2, 2000)), int'($urandom_range(2, 2000)));
    run_st("st_ch2_timeout", int'($urandom_range(2, 100)), 0);

    bus.SELFTEST_START = 1'b1;
    tick();
    bus.SELFTEST_START = 1'b0;
    repeat (3) tick();
    chk_outputs("st_ch1_busy", 8'h43, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_outputs("st_async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    model_cfg = 8'h00;
    model_pass = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk_outputs("st_no_restore", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    bus.SELFTEST_START = 1'b1;
    tick();
    bus.SELFTEST_START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_outputs("start_ignored", model_cfg, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
`endif

    run_cfg("pre_abort", 8'hA5, 1'b0, 1'b0, 8'h00);
    bus.CFG_DATA = 8'hC3;
    bus.CFG_WR = 1'b1;
    tick();
    bus.CFG_WR = 1'b0;
    repeat (2) tick();
    chk_outputs("abort_busy", 8'hA5, 1'b0, 1'b1, 1'b0, model_pass);
    rst = 1'b1;
    #1;
    chk_outputs("abort_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    model_cfg = 8'h00;
    model_pass = 1'b0;
    tick();
    rst = 1'b0;
    repeat (Q + 4) tick();
    chk_outputs("abort_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cfg("after_abort", 8'h96, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
